db_nwr_initiator: RTL

//  Initiator-side sequencer feeding the target's doorbell/NWRITE responder over SRIO ireq/iresp streams.
//  On start:
//  - sends a self-check doorbell (info 0x0101) and waits for the ready/not-ready doorbell reply;
//  - when the target is ready, sends one NWRITE (FTYPE 5, TTYPE 4) with a fixed data pattern;
//  - closes with a data-integration doorbell (0x0200) and checks that the info field comes back echoed.

---
 rtl/db_nwr_initiator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/db_nwr_initiator.sv
// Initiator-side doorbell/NWRITE sequencer for an SRIO ireq/iresp link.
// Runs a self-check doorbell handshake, one NWRITE burst, then a data-integration doorbell.
module db_nwr_initiator #(
  parameter int NWR_BEATS   = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 4
) (
  input  logic        log_clk,
  input  logic        log_rst_n,
  input  logic [15:0] src_id,
  input  logic [15:0] des_id,
  input  logic        start_in,
  input  logic [33:0] nwr_addr_in,
  input  logic        ireq_tready_in,
  output logic        ireq_tvalid_o,
  output logic        ireq_tlast_o,
  output logic [63:0] ireq_tdata_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic [31:0] ireq_tuser_o,
  input  logic        iresp_tvalid_in,
  output logic        iresp_tready_o,
  input  logic        iresp_tlast_in,
  input  logic [63:0] iresp_tdata_in,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  retry_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_SELF_DB, S_WAIT_SELF, S_NWR_HDR, S_NWR_DATA,
    S_DATA_DB, S_WAIT_DATA, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0]  NWR_SIZE  = 8'(NWR_BEATS * 8 - 1);
  localparam logic [7:0]  LAST_BEAT = 8'(NWR_BEATS - 1);
  localparam logic [10:0] TMO_LAST  = 11'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  localparam logic [15:0] INFO_SELF     = 16'h0101;
  localparam logic [15:0] INFO_READY    = 16'h0100;
  localparam logic [15:0] INFO_NOTREADY = 16'h01FF;
  localparam logic [15:0] INFO_DATA     = 16'h0200;

  state_t      state_q, state_d;
  logic [33:0] addr_q;
  logic [7:0]  tid_q;
  logic [7:0]  beat_q;
  logic [10:0] timer_q;
  logic [2:0]  retry_q;
  logic        err_q;

  logic        accept;
  logic        db_rsp;
  logic [15:0] rsp_info;
  logic        timeout;
  logic        in_wait;

  function automatic logic [63:0] doorbell(input logic [7:0] tid, input logic [15:0] info);
    return {tid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, info, 16'h0};
  endfunction

  assign accept   = ireq_tvalid_o && ireq_tready_in;
  assign db_rsp   = iresp_tvalid_in && (iresp_tdata_in[55:52] == 4'hA);
  assign rsp_info = iresp_tdata_in[31:16];
  assign timeout  = (timer_q == TMO_LAST);
  assign in_wait  = (state_q == S_WAIT_SELF) || (state_q == S_WAIT_DATA);

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ireq_tvalid_o = 1'b0;
    ireq_tlast_o  = 1'b0;
    ireq_tdata_o  = 64'h0;
    unique case (state_q)
      S_IDLE: if (start_in) state_d = S_SELF_DB;
      S_SELF_DB: begin
        ireq_tvalid_o = 1'b1;
        ireq_tlast_o  = 1'b1;
        ireq_tdata_o  = doorbell(tid_q, INFO_SELF);
        if (accept) state_d = S_WAIT_SELF;
      end
      S_WAIT_SELF: begin
        // A ready reply outranks a timeout landing in the same cycle.
        if (db_rsp && rsp_info == INFO_READY)
          state_d = S_NWR_HDR;
        else if ((db_rsp && rsp_info == INFO_NOTREADY) || timeout)
          state_d = (retry_q < RETRY_MAX) ? S_SELF_DB : S_ERR;
      end
      S_NWR_HDR: begin
        ireq_tvalid_o = 1'b1;
        ireq_tdata_o  = {tid_q, 4'h5, 4'h4, 1'b0, 2'h1, 1'b0, NWR_SIZE, 2'b0, addr_q};
        if (accept) state_d = S_NWR_DATA;
      end
      S_NWR_DATA: begin
        ireq_tvalid_o = 1'b1;
        ireq_tlast_o  = (beat_q == LAST_BEAT);
        ireq_tdata_o  = {8{beat_q}};
        if (accept && ireq_tlast_o) state_d = S_DATA_DB;
      end
      S_DATA_DB: begin
        ireq_tvalid_o = 1'b1;
        ireq_tlast_o  = 1'b1;
        ireq_tdata_o  = doorbell(tid_q, INFO_DATA);
        if (accept) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (db_rsp)
          state_d = (rsp_info == INFO_DATA) ? S_DONE : S_ERR;
        else if (timeout)
          state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge log_clk) begin
    if (!log_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tid_q   <= '0;
      beat_q  <= '0;
      timer_q <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && start_in) begin
        addr_q  <= nwr_addr_in;
        retry_q <= '0;
        err_q   <= 1'b0;
      end

      if (accept && ireq_tlast_o) tid_q <= tid_q + 8'd1;
      if (accept && state_q == S_SELF_DB) retry_q <= retry_q + 3'd1;

      if (accept && (state_q == S_SELF_DB || state_q == S_DATA_DB))
        timer_q <= '0;
      else if (in_wait && timer_q != '1)
        timer_q <= timer_q + 11'd1;

      if (accept && state_q == S_NWR_HDR)
        beat_q <= '0;
      else if (accept && state_q == S_NWR_DATA)
        beat_q <= beat_q + 8'd1;

      if (state_d == S_ERR) err_q <= 1'b1;
    end
  end

  assign ireq_tkeep_o   = ireq_tvalid_o ? 8'hff : 8'h00;
  assign ireq_tuser_o   = ireq_tvalid_o ? {src_id, des_id} : 32'h0;
  assign iresp_tready_o = 1'b1;
  assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = err_q;
  assign retry_cnt_o    = retry_q;

  // Response fields this initiator never inspects.
  logic unused_rsp_bits;
  assign unused_rsp_bits = ^{iresp_tlast_in, iresp_tdata_in[63:56], iresp_tdata_in[51:32],
                             iresp_tdata_in[15:0]};

endmodule
